// File: rtl/uart_rx_fsm.sv
// UART receiver control FSM: detects the start edge, runs oversampling edge/bit
// counters and issues single-cycle check/shift strobes plus the frame-accepted pulse.
module uart_rx_fsm #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      strt_glitch,
  input  logic                      par_err,
  input  logic                      stp_err,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [3:0]                bit_cnt,
  output logic                      dat_samp_en,
  output logic                      strt_chk_en,
  output logic                      deser_en,
  output logic                      par_chk_en,
  output logic                      stp_chk_en,
  output logic                      data_valid
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state;
  state_t next_state;

  logic                      par_en_q;
  logic                      par_flag;
  logic [PRESCALE_WIDTH-1:0] check_point;
  logic [PRESCALE_WIDTH-1:0] check_point_next;
  logic [PRESCALE_WIDTH-1:0] bit_end;
  logic                      at_cp;
  logic                      at_be;
  logic                      last_data_bit;
  logic                      enter_start;
  logic                      clear_cnt;

  // Check point sits one cycle after the last of the three majority samples.
  assign check_point      = (Prescale >> 1) + PRESCALE_WIDTH'(2);
  assign check_point_next = check_point + PRESCALE_WIDTH'(1);
  assign bit_end          = Prescale - PRESCALE_WIDTH'(1);
  assign at_cp            = (edge_cnt == check_point);
  assign at_be            = (edge_cnt == bit_end);
  assign last_data_bit    = (bit_cnt == 4'(DATA_WIDTH));

  assign enter_start = (next_state == START) && (state != START);
  assign clear_cnt   = (state == IDLE) || (next_state == IDLE) ||
                       ((state == STOP) && (next_state == START));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    dat_samp_en = (state != IDLE);
    strt_chk_en = 1'b0;
    deser_en    = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    data_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (!RX_IN) begin
          next_state = START;
        end
      end
      START: begin
        strt_chk_en = at_cp;
        if (at_be) begin
          next_state = strt_glitch ? IDLE : DATA;
        end
      end
      DATA: begin
        deser_en = at_cp;
        if (at_be && last_data_bit) begin
          next_state = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        par_chk_en = at_cp;
        if (at_be) begin
          next_state = STOP;
        end
      end
      STOP: begin
        stp_chk_en = at_cp;
        if (at_be) begin
          data_valid = !stp_err && !(par_en_q && par_flag);
          // A low line at the stop bit end is the next frame's start bit.
          next_state = RX_IN ? IDLE : START;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (clear_cnt) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (at_be) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + PRESCALE_WIDTH'(1);
    end
  end

  // Frame-wide parity mode and the registered parity verdict for this frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_en_q <= 1'b0;
      par_flag <= 1'b0;
    end else if (enter_start) begin
      par_en_q <= PAR_EN;
      par_flag <= 1'b0;
    end else if ((state == PARITY) && (edge_cnt == check_point_next)) begin
      par_flag <= par_err;
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm: frame drivers push expected strobe events,
// a negedge monitor pops and compares whenever any strobe or data_valid is seen.
module tb_uart_rx_fsm;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic [5:0] Prescale;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en;
  logic       strt_chk_en;
  logic       deser_en;
  logic       par_chk_en;
  logic       stp_chk_en;
  logic       data_valid;

  typedef struct {
    int kind;
    int cyc;
    int ecnt;
    int bcnt;
  } ev_t;

  ev_t   sb[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  string kname[5] = '{"strt_chk", "deser", "par_chk", "stp_chk", "data_valid"};

  uart_rx_fsm #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK(CLK),
    .RST(RST),
    .RX_IN(RX_IN),
    .PAR_EN(PAR_EN),
    .Prescale(Prescale),
    .strt_glitch(strt_glitch),
    .par_err(par_err),
    .stp_err(stp_err),
    .edge_cnt(edge_cnt),
    .bit_cnt(bit_cnt),
    .dat_samp_en(dat_samp_en),
    .strt_chk_en(strt_chk_en),
    .deser_en(deser_en),
    .par_chk_en(par_chk_en),
    .stp_chk_en(stp_chk_en),
    .data_valid(data_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic push_event(input int kind, input int c, input int e, input int b);
    ev_t ev;
    ev.kind = kind;
    ev.cyc  = c;
    ev.ecnt = e;
    ev.bcnt = b;
    sb.push_back(ev);
  endtask

  task automatic check_event(input int kind);
    ev_t ev;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("[TB] FAIL event: got %s at cycle %0d edge %0d bit %0d expected no event",
               kname[kind], cyc, edge_cnt, bit_cnt);
    end else begin
      ev = sb.pop_front();
      if (ev.kind != kind || ev.cyc != cyc || ev.ecnt != int'(edge_cnt) ||
          ev.bcnt != int'(bit_cnt)) begin
        bad++;
        $display("[TB] FAIL event: got %s cyc %0d edge %0d bit %0d expected %s cyc %0d edge %0d bit %0d",
                 kname[kind], cyc, edge_cnt, bit_cnt, kname[ev.kind], ev.cyc, ev.ecnt, ev.bcnt);
      end
    end
  endtask

  always @(negedge CLK) begin
    logic [4:0] s;
    s = {data_valid, stp_chk_en, par_chk_en, deser_en, strt_chk_en};
    for (int k = 0; k < 5; k++) begin
      if (s[k]) check_event(k);
    end
  end

  // Drives one frame starting at the current cycle; leaves the line at the stop
  // level and returns on the stop-bit-end cycle so a following call is back-to-back.
  task automatic apply_frame(input int p, input logic [7:0] data, input logic pe,
                             input logic perr, input logic serr);
    int          c0;
    int          cp;
    int          n;
    int          kind;
    logic [11:0] bits;
    c0   = cyc;
    cp   = p / 2 + 2;
    n    = pe ? 11 : 10;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = data;
    if (pe) bits[9] = ^data;
    Prescale = 6'(p);
    PAR_EN   = pe;
    for (int k = 0; k < n; k++) begin
      kind = (k == 0) ? 0 : (k <= 8) ? 1 : (k == n - 1) ? 3 : 2;
      push_event(kind, c0 + 1 + k * p + cp, cp, k);
    end
    if (!serr && !(pe && perr)) push_event(4, c0 + n * p, p - 1, n - 1);
    for (int k = 0; k < n; k++) begin
      RX_IN = bits[k];
      if (k == 2) PAR_EN = ~pe;
      for (int j = 0; j < p; j++) begin
        @(posedge CLK);
        #1;
        if (j == cp + 1) begin
          if (k == 0) begin
            strt_glitch = 1'b0;
            par_err     = 1'b0;
            stp_err     = 1'b0;
          end else if (k == n - 1) begin
            stp_err = serr;
          end else if (pe && k == 9) begin
            par_err = perr;
          end
        end
      end
    end
  endtask

  // Called on the stop-bit-end cycle of a frame that ends with an idle line.
  task automatic check_frame_end(input string name, input int stop_bit);
    @(negedge CLK);
    check_output({name, "_stop_active"}, dat_samp_en, 1);
    check_output({name, "_stop_bit_cnt"}, bit_cnt, stop_bit);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    check_output({name, "_idle_after"}, dat_samp_en, 0);
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_glitch(input int p);
    int c0;
    int cp;
    c0 = cyc;
    cp = p / 2 + 2;
    Prescale = 6'(p);
    PAR_EN   = 1'b0;
    push_event(0, c0 + 1 + cp, cp, 0);
    RX_IN = 1'b0;
    for (int j = 0; j < p; j++) begin
      @(posedge CLK);
      #1;
      if (j == 2) RX_IN = 1'b1;
      if (j == cp + 1) strt_glitch = 1'b1;
    end
    @(negedge CLK);
    check_output("glitch_be_edge", edge_cnt, p - 1);
    check_output("glitch_be_active", dat_samp_en, 1);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    check_output("glitch_idle", dat_samp_en, 0);
    check_output("glitch_edge_clr", edge_cnt, 0);
    @(posedge CLK);
    #1;
    strt_glitch = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
  endtask

  initial begin
    int c0;
    RST         = 1'b1;
    RX_IN       = 1'b1;
    PAR_EN      = 1'b0;
    Prescale    = 6'd8;
    strt_glitch = 1'b0;
    par_err     = 1'b0;
    stp_err     = 1'b0;
    #1 RST = 1'b0;
    #2;
    check_output("reset_outputs",
                 {edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en,
                  stp_chk_en, data_valid}, 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_output("idle_no_sample", dat_samp_en, 0);

    $display("[TB] frame P=8 no parity 0xA5");
    apply_frame(8, 8'hA5, 1'b0, 1'b0, 1'b0);
    check_frame_end("p8_a5", 9);

    $display("[TB] frame P=16 parity error");
    apply_frame(16, 8'h3C, 1'b1, 1'b1, 1'b0);
    check_frame_end("p16_perr", 10);

    $display("[TB] start glitch P=8");
    apply_glitch(8);

    $display("[TB] frame P=32 stop error");
    apply_frame(32, 8'h81, 1'b0, 1'b0, 1'b1);
    check_frame_end("p32_serr", 9);

    $display("[TB] frame P=16 parity good");
    apply_frame(16, 8'h96, 1'b1, 1'b0, 1'b0);
    check_frame_end("p16_pok", 10);

    $display("[TB] back-to-back frames P=8");
    apply_frame(8, 8'h3C, 1'b0, 1'b0, 1'b0);
    fork
      begin
        @(posedge CLK);
        @(negedge CLK);
        check_output("b2b_start_active", dat_samp_en, 1);
        check_output("b2b_start_edge", edge_cnt, 0);
        check_output("b2b_start_bit", bit_cnt, 0);
      end
    join_none
    apply_frame(8, 8'hC3, 1'b0, 1'b0, 1'b0);
    check_frame_end("b2b_second", 9);

    $display("[TB] reset mid-data P=8");
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    c0 = cyc;
    push_event(0, c0 + 7, 6, 0);
    for (int k = 1; k <= 3; k++) push_event(1, c0 + 7 + k * 8, 6, k);
    RX_IN = 1'b0;
    repeat (35) @(posedge CLK);
    #1;
    check_output("rst_pre_bit_cnt", bit_cnt, 4);
    check_output("rst_pre_edge_cnt", edge_cnt, 2);
    RST = 1'b0;
    #1;
    check_output("rst_mid_outputs",
                 {edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en,
                  stp_chk_en, data_valid}, 0);
    check_output("rst_sb_drained", sb.size(), 0);
    RX_IN = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    repeat (40) @(posedge CLK);
    #1;
    check_output("rst_stays_idle", dat_samp_en, 0);

    $display("[TB] recovery frame P=8 parity good");
    apply_frame(8, 8'h5A, 1'b1, 1'b0, 1'b0);
    check_frame_end("recover", 10);

    repeat (10) @(posedge CLK);
    #1;
    check_output("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
